grf_write_arbiter: RTL and testbench
====================================

Name: grf_write_arbiter

Overview:
- Writer-side front end for the general register file's single write port (WE/WA/WD).
- Merges two producers into one registered write stream:
  - the in-order pipeline W stage;
  - an out-of-band auxiliary producer (multi-cycle unit results, valid/ready).
- Buffers aux results in a small FIFO and resolves WAW ordering against the pipeline.
- Exposes pending-write queries so decode can stall on registers not yet written.

Parameters:
DEPTH, 4, aux FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, consecutive starved cycles before pipeline is stalled (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pipe_we  in  1  W-stage write request
pipe_wa  in  5  W-stage destination
pipe_wd  in  32  W-stage data
pipe_pc  in  32  W-stage PC (trace only)
pipe_stall  out  1  W stage must hold; pipe_* ignored this cycle
aux_valid  in  1  aux result offered
aux_ready  out  1  aux result accepted when valid&ready
aux_wa  in  5  aux destination
aux_wd  in  32  aux data
aux_pc  in  32  aux PC (trace only)
grf_we  out  1  GRF write enable (registered)
grf_wa  out  5  GRF write address (registered)
grf_wd  out  32  GRF write data (registered)
grf_pc  out  32  PC of current write (registered)
q_rs  in  5  query address 1
q_rt  in  5  query address 2
rs_pending  out  1  a live FIFO entry targets q_rs (0 if q_rs==0)
rt_pending  out  1  same for q_rt
fifo_count  out  clog2(DEPTH)+1  live FIFO entries

Behaviour:
- Reset: all outputs 0 except aux_ready=1; FIFO emptied; starve counter 0. Reset mid-transfer discards queued entries, with no GRF write.
- Output register selection each cycle; result appears on grf_* the next cycle:
  - 1) pipe_stall==0 and pipe_we and pipe_wa!=0 -> pipe write (1-cycle latency);
  - 2) else FIFO non-empty -> pop head and present it;
  - 3) else grf_we=0; grf_wa, grf_wd, grf_pc hold their previous values.
- Writes with pipe_wa==0 are no-ops: grf_we is not asserted.
- aux_ready = (fifo_count < DEPTH); it is combinational on the current count only.
  - No same-cycle push-through into a pop slot, so a full FIFO stays not-ready even in a cycle where it pops.
- Accepted aux entries with aux_wa==0 are consumed but not enqueued.
- Minimum aux latency: accept at cycle N, pop at N+1, grf_we at N+2.
- Push and pop in the same cycle are allowed; fifo_count reflects both.
- WAW rule:
  - A pipe write that is selected (case 1) kills every live FIFO entry with the same address, including an entry being pushed that same cycle.
  - Killed entries are removed immediately, never written, and fifo_count drops accordingly.
  - The FIFO keeps relative order of survivors (compaction or per-entry valid bits, implementer's choice; observable order must match arrival order).
- Starvation:
  - The counter increments on each cycle where the FIFO is non-empty and no pop occurs.
  - It clears on any pop or when the FIFO is empty.
  - When counter==STARVE_LIMIT, pipe_stall=1 (combinational from the counter). That cycle the head is popped, pipe_* are ignored, and the counter clears.
  - pipe_stall is therefore high for exactly one cycle per starvation event.
- Pending queries: combinational over live FIFO entries only.
  - The output register is excluded; the GRF forwards its own in-flight write.
  - Address 0 is never pending.

Optional Feature:
GRF_WRITE_TRACE_EN:
- Defined: on every posedge where grf_we==1 and rst==0, print "@<grf_pc hex8>: $<grf_wa dec2> <= <grf_wd hex8>". The print is simulation-only and has no effect on timing.
- Undefined: no trace logic is compiled; ports are unchanged.

Test Plan:
- Reset with FIFO holding 2 entries -> next cycle fifo_count=0, grf_we=0, aux_ready=1, no write appears afterwards.
- pipe_we=1, wa=5, wd=0x1234 at cycle N (FIFO empty) -> cycle N+1 grf_we=1, grf_wa=5, grf_wd=0x1234; pipe_wa=0 -> grf_we stays 0.
- aux pushes wa=3 and wa=7 back-to-back with pipe idle -> writes $3 at N+2 and $7 at N+3; rs_pending(q_rs=3)=1 until the $3 entry pops.
- Fill FIFO with DEPTH entries -> aux_ready=0; with valid held high, the next entry is accepted only after a pop; no entry is lost or duplicated.
- FIFO holds wa=9 (0xAAAA); pipe writes wa=9 (0xBBBB) -> entry killed, fifo_count decrements, only 0xBBBB reaches the GRF, rs_pending(9) drops next cycle.
- Pipe writes every cycle with 1 aux entry queued, STARVE_LIMIT=8 -> pipe_stall pulses for 1 cycle after 8 starved cycles; the aux write appears the following cycle; the pipe write of the stalled cycle appears after re-presentation.

Source files
------------

// File: rtl/grf_write_arbiter.sv
// Merges the W-stage write and a FIFO of auxiliary results onto the single GRF write port.
// Optional `GRF_WRITE_TRACE_EN prints every committed write.
module grf_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pipe_we,
    input  logic [4:0]              pipe_wa,
    input  logic [31:0]             pipe_wd,
    input  logic [31:0]             pipe_pc,
    output logic                    pipe_stall,
    input  logic                    aux_valid,
    output logic                    aux_ready,
    input  logic [4:0]              aux_wa,
    input  logic [31:0]             aux_wd,
    input  logic [31:0]             aux_pc,
    output logic                    grf_we,
    output logic [4:0]              grf_wa,
    output logic [31:0]             grf_wd,
    output logic [31:0]             grf_pc,
    input  logic [4:0]              q_rs,
    input  logic [4:0]              q_rt,
    output logic                    rs_pending,
    output logic                    rt_pending,
    output logic [$clog2(DEPTH):0]  fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    // Entries 0..cnt_q-1 are live, entry 0 is the oldest.
    logic [4:0]    ent_wa_q [DEPTH];
    logic [4:0]    ent_wa_d [DEPTH];
    logic [31:0]   ent_wd_q [DEPTH];
    logic [31:0]   ent_wd_d [DEPTH];
    logic [31:0]   ent_pc_q [DEPTH];
    logic [31:0]   ent_pc_d [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          grf_we_q, grf_we_d;
    logic [4:0]    grf_wa_q, grf_wa_d;
    logic [31:0]   grf_wd_q, grf_wd_d;
    logic [31:0]   grf_pc_q, grf_pc_d;

    logic stall;
    logic pipe_sel;
    logic pop;
    logic push;

    assign aux_ready = (cnt_q < CW'(DEPTH));

    always_comb begin
        stall    = (starve_q == SW'(STARVE_LIMIT));
        pipe_sel = !stall && pipe_we && (pipe_wa != 5'd0);
        pop      = !pipe_sel && (cnt_q != '0);
        // An incoming entry hit by the same-cycle pipe write is dropped on arrival.
        push     = aux_valid && aux_ready && (aux_wa != 5'd0)
                   && !(pipe_sel && (aux_wa == pipe_wa));
    end

    // Rebuild the queue: drop the popped head and killed entries, keep order, append push.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_wa_d[i] = ent_wa_q[i];
            ent_wd_d[i] = ent_wd_q[i];
            ent_pc_d[i] = ent_pc_q[i];
        end
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < cnt_q) && !(pop && (i == 0))
                && !(pipe_sel && (ent_wa_q[i] == pipe_wa))) begin
                ent_wa_d[cnt_d[AW-1:0]] = ent_wa_q[i];
                ent_wd_d[cnt_d[AW-1:0]] = ent_wd_q[i];
                ent_pc_d[cnt_d[AW-1:0]] = ent_pc_q[i];
                cnt_d = cnt_d + 1'b1;
            end
        end
        if (push) begin
            ent_wa_d[cnt_d[AW-1:0]] = aux_wa;
            ent_wd_d[cnt_d[AW-1:0]] = aux_wd;
            ent_pc_d[cnt_d[AW-1:0]] = aux_pc;
            cnt_d = cnt_d + 1'b1;
        end
    end

    always_comb begin
        if ((cnt_q == '0) || pop) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end else begin
            starve_d = starve_q;
        end
    end

    always_comb begin
        grf_we_d = 1'b0;
        grf_wa_d = grf_wa_q;
        grf_wd_d = grf_wd_q;
        grf_pc_d = grf_pc_q;
        if (pipe_sel) begin
            grf_we_d = 1'b1;
            grf_wa_d = pipe_wa;
            grf_wd_d = pipe_wd;
            grf_pc_d = pipe_pc;
        end else if (pop) begin
            grf_we_d = 1'b1;
            grf_wa_d = ent_wa_q[0];
            grf_wd_d = ent_wd_q[0];
            grf_pc_d = ent_pc_q[0];
        end
    end

    // The output register is deliberately excluded: the GRF forwards its own in-flight write.
    always_comb begin
        rs_pending = 1'b0;
        rt_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < cnt_q) begin
                if ((q_rs != 5'd0) && (ent_wa_q[i] == q_rs)) rs_pending = 1'b1;
                if ((q_rt != 5'd0) && (ent_wa_q[i] == q_rt)) rt_pending = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            starve_q <= '0;
            grf_we_q <= 1'b0;
            grf_wa_q <= 5'd0;
            grf_wd_q <= 32'd0;
            grf_pc_q <= 32'd0;
        end else begin
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            grf_we_q <= grf_we_d;
            grf_wa_q <= grf_wa_d;
            grf_wd_q <= grf_wd_d;
            grf_pc_q <= grf_pc_d;
        end
        for (int i = 0; i < DEPTH; i++) begin
            ent_wa_q[i] <= ent_wa_d[i];
            ent_wd_q[i] <= ent_wd_d[i];
            ent_pc_q[i] <= ent_pc_d[i];
        end
    end

    assign pipe_stall = stall;
    assign fifo_count = cnt_q;
    assign grf_we     = grf_we_q;
    assign grf_wa     = grf_wa_q;
    assign grf_wd     = grf_wd_q;
    assign grf_pc     = grf_pc_q;

`ifdef GRF_WRITE_TRACE_EN
    always_ff @(posedge clk) begin
        if (grf_we_q && !rst) begin
            $display("@%08h: $%02d <= %08h", grf_pc_q, grf_wa_q, grf_wd_q);
        end
    end
`endif

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Bench for grf_write_arbiter: directed vector table, hand-written corner sequences,
// and random traffic checked against a queue-based reference model.
module tb_grf_write_arbiter;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_wa = '0;
    logic [31:0] pipe_wd = '0;
    logic [31:0] pipe_pc = '0;
    logic        pipe_stall;
    logic        aux_valid = 1'b0;
    logic        aux_ready;
    logic [4:0]  aux_wa = '0;
    logic [31:0] aux_wd = '0;
    logic [31:0] aux_pc = '0;
    logic        grf_we;
    logic [4:0]  grf_wa;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic [4:0]  q_rs = '0;
    logic [4:0]  q_rt = '0;
    logic        rs_pending;
    logic        rt_pending;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    grf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
        .pipe_stall(pipe_stall),
        .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_wa(aux_wa), .aux_wd(aux_wd),
        .aux_pc(aux_pc),
        .grf_we(grf_we), .grf_wa(grf_wa), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .q_rs(q_rs), .q_rt(q_rt), .rs_pending(rs_pending), .rt_pending(rt_pending),
        .fifo_count(fifo_count)
    );

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
    } ent_t;

    // Reference model: the FIFO is just an ordered queue of pending writes.
    ent_t        m_q[$];
    int          m_starve = 0;
    logic        m_we = 1'b0;
    logic [4:0]  m_wa = '0;
    logic [31:0] m_wd = '0;
    logic [31:0] m_pc = '0;

    int n_cmp = 0;
    int n_err = 0;
    logic [36:0] wr_log[$];
    logic [36:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_pend(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (m_q[i]) if (m_q[i].wa == a) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive, check against the model at the negedge, advance the model.
    task automatic cycle(input logic r, input logic pwe, input logic [4:0] pwa,
                         input logic [31:0] pwd, input logic av, input logic [4:0] awa,
                         input logic [31:0] awd, input logic [4:0] qs, input logic [4:0] qt,
                         output logic stall_seen, output logic ready_seen,
                         output logic pend_seen);
        int   sz;
        logic sel, pop, acc;
        ent_t e;
        rst = r; pipe_we = pwe; pipe_wa = pwa; pipe_wd = pwd; pipe_pc = pwd ^ 32'h5a5a0000;
        aux_valid = av; aux_wa = awa; aux_wd = awd; aux_pc = ~awd; q_rs = qs; q_rt = qt;
        @(negedge clk);
        chk("aux_ready", {31'd0, aux_ready}, {31'd0, m_q.size() < DEPTH});
        chk("pipe_stall", {31'd0, pipe_stall}, {31'd0, m_starve == STARVE_LIMIT});
        chk("fifo_count", {29'd0, fifo_count}, m_q.size());
        chk("rs_pending", {31'd0, rs_pending}, {31'd0, m_pend(qs)});
        chk("rt_pending", {31'd0, rt_pending}, {31'd0, m_pend(qt)});
        chk("grf_we", {31'd0, grf_we}, {31'd0, m_we});
        chk("grf_wa", {27'd0, grf_wa}, {27'd0, m_wa});
        chk("grf_wd", grf_wd, m_wd);
        chk("grf_pc", grf_pc, m_pc);
        stall_seen = pipe_stall; ready_seen = aux_ready; pend_seen = rs_pending;
        if (grf_we) wr_log.push_back({grf_wa, grf_wd});
        if (r) begin
            m_q.delete(); m_starve = 0; m_we = 0; m_wa = '0; m_wd = '0; m_pc = '0;
        end else begin
            sz  = m_q.size();
            acc = av && (sz < DEPTH);
            sel = (m_starve != STARVE_LIMIT) && pwe && (pwa != 5'd0);
            pop = !sel && (sz > 0);
            m_starve = (sz == 0 || pop) ? 0 : m_starve + 1;
            m_we = 1'b0;
            if (sel) begin
                m_we = 1'b1; m_wa = pwa; m_wd = pwd; m_pc = pwd ^ 32'h5a5a0000;
                for (int i = m_q.size() - 1; i >= 0; i--) if (m_q[i].wa == pwa) m_q.delete(i);
            end else if (pop) begin
                e = m_q.pop_front();
                m_we = 1'b1; m_wa = e.wa; m_wd = e.wd; m_pc = e.pc;
            end
            if (acc && (awa != 5'd0) && !(sel && (awa == pwa))) m_q.push_back('{awa, awd, ~awd});
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        pwe;
        logic [4:0]  pwa;
        logic [31:0] pwd;
        logic        av;
        logic [4:0]  awa;
        logic [31:0] awd;
        logic [4:0]  qs;
        logic        exp_pend;
        logic        exp_we;
        logic [4:0]  exp_wa;
        logic [31:0] exp_wd;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic s, rd, pd;
        int   stall_cyc, n_stalls, didx;
        logic expect_replay;
        logic [31:0] held;

        vecs[0]  = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0,    5'd0, 1'b0, 1'b1, 5'd5, 32'h1234, 0};
        vecs[1]  = '{1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 32'h0,    5'd0, 1'b0, 1'b0, 5'd5, 32'h1234, 0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 32'h33,   5'd3, 1'b0, 1'b0, 5'd5, 32'h1234, 1};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'h77,   5'd3, 1'b1, 1'b1, 5'd3, 32'h33,   1};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd3, 1'b0, 1'b1, 5'd7, 32'h77,   0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd7, 1'b0, 1'b0, 5'd7, 32'h77,   0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'hAAAA, 5'd9, 1'b0, 1'b0, 5'd7, 32'h77,   1};
        vecs[7]  = '{1'b1, 5'd9, 32'hBBBB, 1'b0, 5'd0, 32'h0,    5'd9, 1'b1, 1'b1, 5'd9, 32'hBBBB, 0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd9, 1'b0, 1'b0, 5'd9, 32'hBBBB, 0};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'hDEAD, 5'd0, 1'b0, 1'b0, 5'd9, 32'hBBBB, 0};
        vecs[10] = '{1'b1, 5'd4, 32'h44,   1'b1, 5'd4, 32'h99,   5'd4, 1'b0, 1'b1, 5'd4, 32'h44,   0};
        vecs[11] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd4, 1'b0, 1'b0, 5'd4, 32'h44,   0};
        vecs[12] = '{1'b1, 5'd2, 32'h22,   1'b1, 5'd6, 32'h66,   5'd0, 1'b0, 1'b1, 5'd2, 32'h22,   1};
        vecs[13] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd6, 1'b1, 1'b1, 5'd6, 32'h66,   0};

        // Reset state
        @(posedge clk);
        #1;
        cycle(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, s, rd, pd);
        chk("reset_grf_we", {31'd0, grf_we}, 32'd0);
        chk("reset_aux_ready", {31'd0, aux_ready}, 32'd1);
        chk("reset_count", {29'd0, fifo_count}, 32'd0);

        // Directed vector table
        foreach (vecs[i]) begin
            cycle(1'b0, vecs[i].pwe, vecs[i].pwa, vecs[i].pwd, vecs[i].av, vecs[i].awa,
                  vecs[i].awd, vecs[i].qs, 5'd0, s, rd, pd);
            chk($sformatf("vec%0d_pend", i), {31'd0, pd}, {31'd0, vecs[i].exp_pend});
            chk($sformatf("vec%0d_we", i), {31'd0, grf_we}, {31'd0, vecs[i].exp_we});
            chk($sformatf("vec%0d_wa", i), {27'd0, grf_wa}, {27'd0, vecs[i].exp_wa});
            chk($sformatf("vec%0d_wd", i), grf_wd, vecs[i].exp_wd);
            chk($sformatf("vec%0d_cnt", i), {29'd0, fifo_count}, vecs[i].exp_cnt);
        end

        // Fill the FIFO while the pipe keeps the port busy, then drain with valid held
        cycle(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, s, rd, pd);
        wr_log.delete();
        exp_q.delete();
        for (int k = 0; k < DEPTH; k++) begin
            cycle(1'b0, 1'b1, 5'd1, 32'h100 + k, 1'b1, 5'(10 + k), 32'hA0 + k, 0, 0, s, rd, pd);
            exp_q.push_back({5'(10 + k), 32'hA0 + k});
        end
        cycle(1'b0, 1'b1, 5'd1, 32'h200, 1'b1, 5'd14, 32'hE0, 0, 0, s, rd, pd);
        chk("full_not_ready", {31'd0, rd}, 32'd0);
        chk("full_count", {29'd0, fifo_count}, DEPTH);
        rd = 1'b0;
        for (int t = 0; t < 10 && !rd; t++) begin
            cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'hE0, 0, 0, s, rd, pd);
        end
        chk("full_accept_e", {31'd0, rd}, 32'd1);
        exp_q.push_back({5'd14, 32'hE0});
        for (int t = 0; t < 8; t++) cycle(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, s, rd, pd);
        for (int i = wr_log.size() - 1; i >= 0; i--) if (wr_log[i][36:32] < 5'd10) wr_log.delete(i);
        chk("fill_write_count", wr_log.size(), exp_q.size());
        while (exp_q.size() > 0 && wr_log.size() > 0) begin
            chk("fill_write_order", wr_log.pop_front(), exp_q.pop_front());
        end

        // Starvation: one queued aux entry against back-to-back pipe writes
        cycle(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, s, rd, pd);
        cycle(1'b0, 1'b1, 5'd21, 32'h20FF, 1'b1, 5'd20, 32'h2020, 0, 0, s, rd, pd);
        stall_cyc = -1; n_stalls = 0; didx = 0; expect_replay = 1'b0; held = '0;
        for (int c = 1; c <= 14; c++) begin
            cycle(1'b0, 1'b1, 5'd21, 32'h2100 + didx, 1'b0, 0, 0, 5'd20, 0, s, rd, pd);
            if (expect_replay) begin
                chk("starve_replay_wd", grf_wd, held);
                expect_replay = 1'b0;
            end
            if (s) begin
                n_stalls++;
                stall_cyc = c;
                chk("starve_aux_wa", {27'd0, grf_wa}, 32'd20);
                chk("starve_aux_wd", grf_wd, 32'h2020);
                held = 32'h2100 + didx;
                expect_replay = 1'b1;
            end else begin
                didx++;
            end
        end
        chk("starve_cycle", stall_cyc, STARVE_LIMIT + 1);
        chk("starve_pulses", n_stalls, 1);

        // Reset while two entries are queued
        cycle(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, s, rd, pd);
        cycle(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd11, 32'hB1, 0, 0, s, rd, pd);
        cycle(1'b0, 1'b1, 5'd1, 32'h2, 1'b1, 5'd12, 32'hB2, 0, 0, s, rd, pd);
        chk("midrst_pre_count", {29'd0, fifo_count}, 32'd2);
        cycle(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, s, rd, pd);
        chk("midrst_count", {29'd0, fifo_count}, 32'd0);
        chk("midrst_we", {31'd0, grf_we}, 32'd0);
        chk("midrst_ready", {31'd0, aux_ready}, 32'd1);
        wr_log.delete();
        for (int t = 0; t < 5; t++) cycle(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, s, rd, pd);
        chk("midrst_no_write", wr_log.size(), 0);

        // Random traffic against the model
        for (int t = 0; t < 3000; t++) begin
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 6,
                  5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), s, rd, pd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
